// File: rtl/arith_sched_if.sv
// Request/response bundle for arith_sched: two valid/ready requesters and one tagged response port.
interface arith_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/arith_sched.sv
// Round-robin two-requester scheduler feeding a two-stage add/sub/mul pipeline.
// Multiplier is present only when ARITH_SCHED_MUL_EN is defined; otherwise op 10 yields zero.
module arith_sched (
  input logic          clk,
  input logic          rst,
  arith_sched_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Stage 1: operand register
  logic        s1_valid;
  op_e         s1_op;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;
  logic        s1_id;

  // Stage 2: result register, drives the response port directly
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [15:0] rsp_data_q;

  logic        last;
  logic        adv;
  logic        grant_any;
  logic        grant_id;
  logic        accept;
  op_e         sel_op;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic [15:0] result;

  // The whole pipeline moves together; a stalled response freezes both stages.
  assign adv = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    grant_any = bus.req0_valid || bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = !last;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept         = adv && grant_any && !rst;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  always_comb begin
    sel_op = op_e'(bus.req0_op);
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    if (grant_id) begin
      sel_op = op_e'(bus.req1_op);
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
    end
  end

  always_comb begin
    result = '0;
    case (s1_op)
      OP_ADD: result = {8'h00, s1_a + s1_b};
      OP_SUB: result = {8'h00, s1_a - s1_b};
`ifdef ARITH_SCHED_MUL_EN
      OP_MUL: result = {8'h00, s1_a} * {8'h00, s1_b};
`else
      OP_MUL: result = '0;
`endif
      OP_RSV: result = '0;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      last        <= 1'b1;
    end else if (adv) begin
      rsp_valid_q <= s1_valid;
      if (s1_valid) begin
        rsp_data_q <= result;
        rsp_id_q   <= s1_id;
      end
      s1_valid <= grant_any;
      if (grant_any) begin
        last <= grant_id;
      end
    end
  end

  // Operand payload needs no reset: it is qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (adv && grant_any) begin
      s1_op <= sel_op;
      s1_a  <= sel_a;
      s1_b  <= sel_b;
      s1_id <= grant_id;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = s1_valid || rsp_valid_q;

endmodule

// File: tb/tb_arith_sched.sv
// Self-checking bench for arith_sched: directed scenarios then random traffic against a queue-based model.
module tb_arith_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arith_sched_if bus ();

  arith_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ARITH_SCHED_MUL_EN
  localparam logic [15:0] MUL_EXP = 16'hFE01;
`else
  localparam logic [15:0] MUL_EXP = 16'h0000;
`endif

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 2;
  logic m_last = 1'b1;

  logic       p_valid [2];
  logic [1:0] p_op [2];
  logic [7:0] p_a [2];
  logic [7:0] p_b [2];

  function automatic logic [15:0] ref_op(input int op, input int a, input int b);
    case (op)
      0: return 16'((a + b) % 256);
      1: return 16'((a - b + 256) % 256);
`ifdef ARITH_SCHED_MUL_EN
      2: return 16'(a * b);
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input int op, input int a, input int b);
    p_valid[n] = 1'b1;
    p_op[n]    = 2'(op);
    p_a[n]     = 8'(a);
    p_b[n]     = 8'(b);
  endtask

  // One clock: drive, check against the model, advance the model across the edge.
  task automatic run_cycle(input logic rr, input logic r);
    logic exp_rv, adv, g0, g1, er0, er1;
    int   w, id;
    bus.req0_valid = p_valid[0];
    bus.req0_op    = p_op[0];
    bus.req0_a     = p_a[0];
    bus.req0_b     = p_b[0];
    bus.req1_valid = p_valid[1];
    bus.req1_op    = p_op[1];
    bus.req1_a     = p_a[1];
    bus.req1_b     = p_b[1];
    bus.rsp_ready  = rr;
    rst            = r;
    #1;
    w      = cyc;
    exp_rv = (sb.size() > 0) && (sb[0].due <= w);
    adv    = !exp_rv || rr;
    g0     = p_valid[0] && (!p_valid[1] || m_last);
    g1     = p_valid[1] && (!p_valid[0] || !m_last);
    er0    = adv && g0 && !r;
    er1    = adv && g1 && !r;
    chk("rsp_valid", 16'(bus.rsp_valid), 16'(exp_rv));
    chk("busy", 16'(bus.busy), 16'(sb.size() > 0));
    chk("req0_ready", 16'(bus.req0_ready), 16'(er0));
    chk("req1_ready", 16'(bus.req1_ready), 16'(er1));
    if (exp_rv) begin
      chk("rsp_id", 16'(bus.rsp_id), 16'(sb[0].id));
      chk("rsp_data", bus.rsp_data, sb[0].data);
    end
    last_acc = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : 2);
    @(posedge clk);
    cyc++;
    if (r) begin
      sb.delete();
      m_last = 1'b1;
    end else begin
      if (exp_rv && rr) void'(sb.pop_front());
      if (exp_rv && !rr) foreach (sb[i]) sb[i].due++;
      if (er0 || er1) begin
        id = er1 ? 1 : 0;
        sb.push_back('{id: id, data: ref_op(int'(p_op[id]), int'(p_a[id]), int'(p_b[id])), due: w + 2});
        m_last     = er1;
        p_valid[id] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || p_valid[0] || p_valid[1]) && n < 20) begin
      run_cycle(1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", 16'(sb.size() > 0 || p_valid[0] || p_valid[1]), 16'd0);
  endtask

  initial begin
    int grants [6];
    logic [15:0] hold_data;
    logic hold_id;

    for (int n = 0; n < 2; n++) begin
      p_valid[n] = 1'b0; p_op[n] = '0; p_a[n] = '0; p_b[n] = '0;
    end
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);

    run_cycle(1'b1, 1'b1);
    chk("reset_rsp_data", bus.rsp_data, 16'h0000);
    chk("reset_rsp_id", 16'(bus.rsp_id), 16'd0);
    run_cycle(1'b1, 1'b0);

    set_req(0, 0, 200, 100);
    run_cycle(1'b1, 1'b0);
    chk("add_grant", 16'(last_acc), 16'd0);
    run_cycle(1'b1, 1'b0);
    chk("add_valid", 16'(bus.rsp_valid), 16'd1);
    chk("add_data", bus.rsp_data, 16'h002C);
    chk("add_id", 16'(bus.rsp_id), 16'd0);
    run_cycle(1'b1, 1'b0);
    chk("busy_after_pop", 16'(bus.busy), 16'd0);

    set_req(1, 1, 5, 10);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    chk("sub_data", bus.rsp_data, 16'h00FB);
    chk("sub_id", 16'(bus.rsp_id), 16'd1);
    run_cycle(1'b1, 1'b0);

    set_req(0, 2, 255, 255);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    chk("mul_data", bus.rsp_data, MUL_EXP);
    run_cycle(1'b1, 1'b0);

    set_req(1, 3, 7, 9);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    chk("rsv_data", bus.rsp_data, 16'h0000);
    chk("rsv_valid", 16'(bus.rsp_valid), 16'd1);
    run_cycle(1'b1, 1'b0);

    // Alternation from a fresh pointer
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < 2; n++)
        if (!p_valid[n]) set_req(n, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      run_cycle(1'b1, 1'b0);
      grants[i] = last_acc;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("alt_grant%0d", i), 16'(grants[i]), 16'(i % 2));
    drain();

    // Stall with two operations in flight and a request waiting
    set_req(0, 0, 17, 34);
    set_req(1, 2, 12, 13);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    set_req(0, 1, 3, 9);
    hold_data = bus.rsp_data;
    hold_id   = bus.rsp_id;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0);
      chk("stall_data", bus.rsp_data, hold_data);
      chk("stall_id", 16'(bus.rsp_id), 16'(hold_id));
    end
    drain();

    // Reset with two operations in flight
    set_req(0, 0, 1, 2);
    set_req(1, 0, 3, 4);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    set_req(0, 1, 50, 60);
    set_req(1, 1, 70, 80);
    run_cycle(1'b1, 1'b0);
    chk("post_rst_grant", 16'(last_acc), 16'd0);
    drain();

    // Random traffic with backpressure and occasional reset
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < 2; n++)
        if (!p_valid[n] && $urandom_range(0, 9) < 6)
          set_req(n, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_sched.md
# arith_sched

Two-requester scheduler for the shared 8-bit arithmetic datapath (add, subtract, multiply). It arbitrates round-robin between two valid/ready requesters and issues one operation per cycle into a two-stage pipeline: operand register, then result register. Completed results go out on a single tagged response port with backpressure. The block sits between the control logic that generates operations and the arithmetic unit, replacing the switch-selected, always-running add/sub/mul arrangement.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  00 add, 01 sub, 10 mul, 11 reserved
- req0_a, req0_b  in  8  operands, unsigned
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index that issued the result
- rsp_data  out  16  result
- busy  out  1  any pipeline stage holds a valid operation

## Operation
- Arithmetic:
  - add → {8'h00, (a+b)[7:0]}, carry discarded.
  - sub → {8'h00, (a−b)[7:0]}, two's-complement wrap.
  - mul → full 16-bit a×b.
  - op 11 → 16'h0000.
- Pipeline:
  - S1 holds a, b, op, id and a valid bit.
  - S2 holds rsp_data, rsp_id and rsp_valid.
- Global advance: `adv = !rsp_valid || rsp_ready`.
- When adv is high:
  - S2 ← compute(S1), including S1's valid bit.
  - S1 ← the granted request, or a bubble if no request is granted.
- When adv is low, S1 and S2 hold.
- Arbitration:
  - 1-bit pointer `last` records the last granted requester.
  - Only one valid requester → grant it.
  - Both valid → grant !last.
  - `last` updates only on an accepted transfer.
- Handshakes:
  - reqN_ready = adv && grant==N && !rst. At most one ready is high per cycle.
  - reqN_ready may depend on reqN_valid.
  - A requester holds valid, op, a and b stable until it is accepted.
- Response: rsp_data and rsp_id stay stable while rsp_valid && !rsp_ready.
- busy = S1.valid || rsp_valid.

## Timing
- Reset values (cycle after rst sampled high): rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, last=1, S1.valid=0. This gives requester 0 first priority.
- While rst is high, req0_ready and req1_ready are 0.
- Latency, no stall: request accepted at edge E → rsp_valid high from edge E+2. Throughput is 1 operation/cycle.
- Stall: every cycle with rsp_valid && !rsp_ready adds exactly one cycle to every in-flight operation and blocks acceptance.
- Bubble: when rsp_valid=0, S2 accepts S1 regardless of rsp_ready.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is emitted for them. Requests pending during reset are accepted only after rst deasserts.
- Simultaneous response pop and new accept in the same cycle is permitted; no bubble is inserted.

## Configuration
- Macro ARITH_SCHED_MUL_EN.
- Defined: op 10 returns the 16-bit product.
- Undefined: no multiplier is instantiated; op 10 returns 16'h0000 with normal latency, id and handshake, the same as op 11.

## Test plan
- Reset, then req0 add a=200 b=100, rsp_ready=1 → req0_ready=1 in the issue cycle; rsp_valid at E+2 with rsp_id=0, rsp_data=16'h002C; busy falls after the pop.
- req1 sub a=5 b=10 → rsp_data=16'h00FB, rsp_id=1.
- req0 mul a=255 b=255 → 16'hFE01 with ARITH_SCHED_MUL_EN defined; 16'h0000 without it. Op 11 → 16'h0000 in both builds.
- Both requesters valid continuously for 6 cycles, rsp_ready=1 → grants 0,1,0,1,0,1; back-to-back responses, one per cycle; ids alternate.
- rsp_ready=0 for 3 cycles while 2 operations are in flight → rsp_data/rsp_id stable, both readies 0. On release, results drain in order with no loss or duplication.
- rst pulsed one cycle with 2 operations in flight → rsp_valid=0 and busy=0 next cycle; no stale result appears afterwards; the next grant goes to req0 when both are valid.
